debounced_reg_memory: RTL

Parametrised, clocked successor to the 4-byte latch memory on the Basys3 board. The block holds DEPTH words of WIDTH bits in flip-flops and writes one word per debounced press of a raw push-button. It reads either the addressed word or an auto-scanning display pointer. The top level drives it from switches and btnC and feeds its read port to the LEDs.

---
 rtl/debounced_reg_memory_pkg.sv | 9 +
 rtl/debounced_reg_memory_btn_debounce.sv | 45 ++++
 rtl/debounced_reg_memory.sv | 106 ++++++++++
 3 files changed

// File: rtl/debounced_reg_memory_pkg.sv
// Shared helpers for the debounced register memory.
package debounced_reg_memory_pkg;

   // True when v is a non-zero power of two.
   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/debounced_reg_memory_btn_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer for a raw push-button.
// rise_c is a one-cycle pulse in the cycle after the debounced level goes high.
module btn_debounce #(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise_c
);

   localparam int unsigned CW = $clog2(DB_CYCLES);

   logic          s1;
   logic          s2;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;

   // Synchronise, count consecutive mismatching cycles, flip level once stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         s1      <= btn;
         s2      <= s1;
         level_d <= level;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYCLES - 1)) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign rise_c = level & ~level_d;

endmodule

// File: rtl/debounced_reg_memory.sv
// Flip-flop word memory written once per debounced button press, with a
// registered read port that shows either the addressed word or a scan pointer.
module debounced_reg_memory
   import debounced_reg_memory_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned DB_CYCLES   = 1_000_000,
   parameter int unsigned SCAN_CYCLES = 100_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           data,
   input  logic [$clog2(DEPTH)-1:0]   addr,
   input  logic                       store,
   input  logic                       scan,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic                       rd_valid,
   output logic                       wr_ack
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

   // Elaboration-time parameter sanity checks.
   if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
      $error("debounced_reg_memory: DEPTH must be a power of two >= 2");
   end
   if (DB_CYCLES < 2) begin : g_bad_db
      $error("debounced_reg_memory: DB_CYCLES must be >= 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic             commit_c;
   logic             scan_d;
   logic [PW-1:0]    pre;
   logic [AW-1:0]    ptr;
   logic [AW-1:0]    sel_c;

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_store_db (
      .clk    (clk),
      .rst    (rst),
      .btn    (store),
      .rise_c (commit_c)
   );

   // Commit one word per debounced press; data and addr sampled at that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         valid <= '0;
      end else if (commit_c) begin
         mem[addr]   <= data;
         valid[addr] <= 1'b1;
      end
   end

   // Scan prescaler and pointer; restart on a scan rising edge, idle at 0 when off.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_d <= 1'b0;
         pre    <= '0;
         ptr    <= '0;
      end else begin
         scan_d <= scan;
         if (!scan || !scan_d) begin
            pre <= '0;
            ptr <= '0;
         end else if (pre == PW'(SCAN_CYCLES - 1)) begin
            pre <= '0;
            ptr <= ptr + AW'(1);
         end else begin
            pre <= pre + PW'(1);
         end
      end
   end

   assign sel_c = scan ? ptr : addr;

   // Registered read port with write-first bypass when commit hits the read address.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_addr  <= '0;
         rd_valid <= 1'b0;
         wr_ack   <= 1'b0;
      end else begin
         rd_addr <= sel_c;
         wr_ack  <= commit_c;
         if (commit_c && (addr == sel_c)) begin
            rd_data  <= data;
            rd_valid <= 1'b1;
         end else begin
            rd_data  <= mem[sel_c];
            rd_valid <= valid[sel_c];
         end
      end
   end

endmodule
